// File: rtl/load_control.sv
// load_control: loads a program into instruction memory from a UART byte stream.
// The frame is a 32-bit word count N followed by N 32-bit instruction words,
// each sent as four bytes MSB first. Each completed instruction word produces
// a one-cycle IM_we pulse. A zero count ends the load at once, and a count
// larger than the memory depth is rejected with a load_error pulse.
module load_control #(
  parameter int IM_ADDR_LENGTH = 32,
  parameter int IM_MEM_SIZE    = 1024,
  parameter int DATA_WIDTH     = 32,
  parameter int UART_BITS      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UART_BITS-1:0]      rx_Data,
  input  logic                      rx_done,
  input  logic                      load_flag,
  output logic [IM_ADDR_LENGTH-1:0] IM_Addr,
  output logic [DATA_WIDTH-1:0]     IM_Data,
  output logic                      IM_we,
  output logic                      load_done,
  output logic                      load_error
);

  // One-hot state encoding; any other pattern is treated as illegal.
  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    GETCNT  = 6'b000010,
    GETINST = 6'b000100,
    WRITE   = 6'b001000,
    DONE    = 6'b010000,
    ERROR   = 6'b100000
  } state_t;

  localparam logic [DATA_WIDTH-1:0] MEM_SIZE_W = DATA_WIDTH'(IM_MEM_SIZE);

  state_t                    state;
  logic [1:0]                byte_cnt;
  logic [DATA_WIDTH-1:0]     shift;
  logic [IM_ADDR_LENGTH-1:0] word_cnt;
  logic [IM_ADDR_LENGTH-1:0] word_idx;

  // Word as it will look once the byte on rx_Data is shifted in.
  logic [DATA_WIDTH-1:0]     shift_nxt;
  logic                      last_byte;
  logic [IM_ADDR_LENGTH-1:0] idx_inc;

  assign shift_nxt = {shift[DATA_WIDTH-UART_BITS-1:0], rx_Data};
  assign last_byte = (byte_cnt == 2'd3);
  assign idx_inc   = word_idx + IM_ADDR_LENGTH'(1);

  // Load sequencer: byte assembly, count check, memory write pulses, status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      shift      <= '0;
      word_cnt   <= '0;
      word_idx   <= '0;
      IM_Addr    <= '0;
      IM_Data    <= '0;
      IM_we      <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      // Pulse outputs default low; individual states raise them for one cycle.
      IM_we      <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      case (state)
        IDLE: begin
          IM_Addr  <= '0;
          byte_cnt <= 2'd0;
          if (load_flag) begin
            state <= GETCNT;
          end else begin
            state <= IDLE;
          end
        end
        GETCNT: begin
          if (rx_done) begin
            shift    <= shift_nxt;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              word_cnt <= IM_ADDR_LENGTH'(shift_nxt);
              word_idx <= '0;
              if (shift_nxt == '0) begin
                state <= DONE;
              end else if (shift_nxt > MEM_SIZE_W) begin
                state <= ERROR;
              end else begin
                state <= GETINST;
              end
            end
          end
        end
        GETINST: begin
          if (rx_done) begin
            shift    <= shift_nxt;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              IM_Data <= shift_nxt;
              IM_Addr <= word_idx;
              IM_we   <= 1'b1;
              state   <= WRITE;
            end
          end
        end
        WRITE: begin
          // A byte landing here is the first of the next word; keep it.
          if (rx_done) begin
            shift    <= shift_nxt;
            byte_cnt <= byte_cnt + 2'd1;
          end
          word_idx <= idx_inc;
          if (idx_inc == word_cnt) begin
            state <= DONE;
          end else begin
            state <= GETINST;
          end
        end
        DONE: begin
          load_done <= 1'b1;
          state     <= IDLE;
        end
        ERROR: begin
          load_error <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_control.sv
// Testbench for load_control: directed vector table, timing corner sequences,
// a full-depth load, and randomized frames checked against a frame-level model.
module tb_load_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_Data = 8'd0;
  logic        rx_done = 1'b0;
  logic        load_flag = 1'b0;
  logic [31:0] IM_Addr;
  logic [31:0] IM_Data;
  logic        IM_we;
  logic        load_done;
  logic        load_error;

  always #5 clk = ~clk;

  load_control dut (
    .clk        (clk),
    .reset      (reset),
    .rx_Data    (rx_Data),
    .rx_done    (rx_done),
    .load_flag  (load_flag),
    .IM_Addr    (IM_Addr),
    .IM_Data    (IM_Data),
    .IM_we      (IM_we),
    .load_done  (load_done),
    .load_error (load_error)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] wr_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] frame_words[$];
  int          done_n = 0;
  int          err_n = 0;
  int          exp_done;
  int          exp_err;
  logic        prev_we = 1'b0;

  typedef struct {
    logic [31:0] cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    int          gap;
    int          exp_we;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: record every write pulse and status pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (IM_we) begin
      wr_q.push_back({IM_Addr, IM_Data});
      check("we_single_cycle", {63'd0, prev_we}, 64'd0);
    end
    if (load_done) done_n++;
    if (load_error) err_n++;
    prev_we = IM_we;
  end

  task automatic clear_mon();
    wr_q.delete();
    done_n = 0;
    err_n = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input logic lf);
    rx_Data = b;
    rx_done = 1'b1;
    load_flag = lf;
    @(negedge clk);
    rx_done = 1'b0;
    load_flag = 1'b0;
    rx_Data = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input logic lf);
    send_byte(w[31:24], gap, lf);
    send_byte(w[23:16], gap, lf);
    send_byte(w[15:8], gap, lf);
    send_byte(w[7:0], gap, lf);
  endtask

  task automatic start_load();
    load_flag = 1'b1;
    @(negedge clk);
    load_flag = 1'b0;
  endtask

  // Frame-level model: what a load with this count and these words must produce.
  task automatic model_frame(input logic [31:0] cnt);
    exp_q.delete();
    exp_done = 0;
    exp_err = 0;
    if (cnt == 32'd0) begin
      exp_done = 1;
    end else if (cnt > 32'd1024) begin
      exp_err = 1;
    end else begin
      for (int i = 0; i < int'(cnt); i++) exp_q.push_back({32'(i), frame_words[i]});
      exp_done = 1;
    end
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
    check({tag, "_done"}, 64'(done_n), 64'(exp_done));
    check({tag, "_err"}, 64'(err_n), 64'(exp_err));
  endtask

  initial begin
    logic [31:0] cnt;
    logic [31:0] w;
    int          nw;
    int          gap;
    logic        legal;

    // Asynchronous reset with no clock edge in between.
    #1 reset = 1'b0;
    #1;
    check("rst_addr", 64'(IM_Addr), 64'd0);
    check("rst_data", 64'(IM_Data), 64'd0);
    check("rst_we", 64'(IM_we), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_err", 64'(load_error), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Bytes without load_flag are ignored in IDLE.
    clear_mon();
    send_word(32'h0000_0001, 0, 1'b0);
    send_word(32'h1111_2222, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("idle_ignore_nwr", 64'(wr_q.size()), 64'd0);
    check("idle_ignore_done", 64'(done_n), 64'd0);

    // Directed vector table.
    tbl[0] = '{32'h0000_0002, 32'h1234_5678, 32'h9ABC_DEF0, 2, 2, 1, 0};
    tbl[1] = '{32'h0000_0002, 32'hA5A5_0001, 32'h5A5A_0002, 0, 2, 1, 0};
    tbl[2] = '{32'h0000_0000, 32'h0102_0304, 32'h0506_0708, 1, 0, 1, 0};
    tbl[3] = '{32'h0000_0401, 32'hFFFF_FFFF, 32'h0000_0001, 1, 0, 0, 1};
    tbl[4] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h1111_1111, 1, 1, 1, 0};
    tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 1};
    tbl[6] = '{32'h8000_0000, 32'h1357_9BDF, 32'h2468_ACE0, 3, 0, 0, 1};
    for (int k = 0; k < 7; k++) begin
      clear_mon();
      start_load();
      send_word(tbl[k].cnt, tbl[k].gap, 1'b0);
      send_word(tbl[k].w0, tbl[k].gap, 1'b0);
      send_word(tbl[k].w1, tbl[k].gap, 1'b0);
      repeat (10) @(negedge clk);
      check($sformatf("tbl%0d_nwr", k), 64'(wr_q.size()), 64'(tbl[k].exp_we));
      for (int i = 0; i < wr_q.size() && i < 2; i++)
        check($sformatf("tbl%0d_wr%0d", k, i), wr_q[i],
              {32'(i), (i == 0) ? tbl[k].w0 : tbl[k].w1});
      check($sformatf("tbl%0d_done", k), 64'(done_n), 64'(tbl[k].exp_done));
      check($sformatf("tbl%0d_err", k), 64'(err_n), 64'(tbl[k].exp_err));
      check($sformatf("tbl%0d_idle_addr", k), 64'(IM_Addr), 64'd0);
      if (tbl[k].exp_we > 0)
        check($sformatf("tbl%0d_data_hold", k), 64'(IM_Data),
              64'((tbl[k].exp_we == 1) ? tbl[k].w0 : tbl[k].w1));
    end

    // Write latency and load_done timing for a one-word load.
    clear_mon();
    start_load();
    send_word(32'h0000_0001, 0, 1'b0);
    send_byte(8'hCA, 0, 1'b0);
    send_byte(8'hFE, 0, 1'b0);
    send_byte(8'hBA, 0, 1'b0);
    send_byte(8'hBE, 0, 1'b0);
    check("lat_we", 64'(IM_we), 64'd1);
    check("lat_addr", 64'(IM_Addr), 64'd0);
    check("lat_data", 64'(IM_Data), 64'hCAFE_BABE);
    @(negedge clk);
    check("lat_we_off", 64'(IM_we), 64'd0);
    check("lat_done_early", 64'(load_done), 64'd0);
    @(negedge clk);
    check("lat_done", 64'(load_done), 64'd1);
    @(negedge clk);
    check("lat_done_off", 64'(load_done), 64'd0);
    check("lat_data_hold", 64'(IM_Data), 64'hCAFE_BABE);

    // Zero count: load_done one cycle after DONE is entered.
    clear_mon();
    start_load();
    send_word(32'h0000_0000, 0, 1'b0);
    check("zero_done_early", 64'(load_done), 64'd0);
    @(negedge clk);
    check("zero_done", 64'(load_done), 64'd1);
    @(negedge clk);
    check("zero_done_off", 64'(load_done), 64'd0);
    check("zero_nwr", 64'(wr_q.size()), 64'd0);

    // Reset in the middle of a three-word load, while a write pulse is high.
    clear_mon();
    start_load();
    send_word(32'h0000_0003, 1, 1'b0);
    send_word(32'h0BAD_F00D, 1, 1'b0);
    send_byte(8'h77, 0, 1'b0);
    send_byte(8'h66, 0, 1'b0);
    send_byte(8'h55, 0, 1'b0);
    send_byte(8'h44, 0, 1'b0);
    check("mid_we_before", 64'(IM_we), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_we", 64'(IM_we), 64'd0);
    check("mid_rst_data", 64'(IM_Data), 64'd0);
    check("mid_rst_addr", 64'(IM_Addr), 64'd0);
    check("mid_rst_done", 64'(load_done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    send_word(32'h9999_8888, 0, 1'b0);
    repeat (8) @(negedge clk);
    check("mid_nwr", 64'(wr_q.size()), 64'd2);
    check("mid_no_done", 64'(done_n), 64'd0);
    clear_mon();
    start_load();
    send_word(32'h0000_0001, 1, 1'b0);
    send_word(32'hFEED_0042, 1, 1'b0);
    repeat (8) @(negedge clk);
    check("mid_reload_nwr", 64'(wr_q.size()), 64'd1);
    if (wr_q.size() > 0) check("mid_reload_wr", wr_q[0], {32'd0, 32'hFEED_0042});
    check("mid_reload_done", 64'(done_n), 64'd1);

    // Full-depth load of 1024 words, bytes back to back.
    clear_mon();
    frame_words.delete();
    for (int i = 0; i < 1024; i++) frame_words.push_back($urandom);
    model_frame(32'h0000_0400);
    start_load();
    send_word(32'h0000_0400, 0, 1'b0);
    for (int i = 0; i < 1024; i++) send_word(frame_words[i], 0, 1'b0);
    repeat (10) @(negedge clk);
    compare_frame("full");
    if (wr_q.size() == 1024) check("full_last_addr", 64'(wr_q[1023][63:32]), 64'h3FF);

    // Randomized frames with random byte gaps and stray load_flag pulses.
    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 4))
        0:       cnt = 32'd0;
        4: begin
          cnt = $urandom;
          if (cnt <= 32'd1024) cnt = cnt + 32'd1025;
        end
        default: cnt = 32'($urandom_range(1, 6));
      endcase
      legal = (cnt != 32'd0) && (cnt <= 32'd1024);
      nw = legal ? int'(cnt) : 2;
      frame_words.delete();
      for (int i = 0; i < nw; i++) frame_words.push_back($urandom);
      model_frame(cnt);
      clear_mon();
      start_load();
      for (int b = 0; b < 4 * (nw + 1); b++) begin
        w = (b < 4) ? cnt : frame_words[b / 4 - 1];
        gap = $urandom_range(0, 3);
        if ((b < 4 && cnt == 32'd0) || (!legal && b >= 4)) begin
          send_byte(w[31 - 8 * (b % 4) -: 8], gap, 1'b0);
        end else begin
          send_byte(w[31 - 8 * (b % 4) -: 8], gap,
                    legal && (b < 4 * (nw + 1) - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
      end
      repeat (10) @(negedge clk);
      compare_frame($sformatf("rnd%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_control.md
LOAD_CONTROL -- requirements
Module: load_control

Interface
REQ-001 Parameters: IM_ADDR_LENGTH, 32, instruction-memory address width; IM_MEM_SIZE, 1024, instruction-memory depth in words; DATA_WIDTH, 32, instruction width; UART_BITS, 8, UART RX byte width.
REQ-002 Ports, in order:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_Data  in  UART_BITS  received byte; valid only while rx_done=1.
- rx_done  in  1  one-cycle pulse per received byte.
- load_flag  in  1  start-load request; sampled only in IDLE.
- IM_Addr  out  IM_ADDR_LENGTH  instruction-memory write address.
- IM_Data  out  DATA_WIDTH  instruction-memory write data.
- IM_we  out  1  instruction-memory write enable; one-cycle pulse per word.
- load_done  out  1  one-cycle pulse when the load completes.
- load_error  out  1  one-cycle pulse when the word count is rejected.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 All outputs SHALL be driven directly from registers.

Function
REQ-005 States SHALL be one-hot: IDLE, GETCNT, GETINST, WRITE, DONE, ERROR.
REQ-006 Frame format: one 32-bit word count N, then N 32-bit instruction words.
- Each word is 4 bytes, MSB first.
- Assembly: shift = {shift[23:0], rx_Data} on every accepted rx_done.
- A 2-bit byte counter wraps from 3 to 0.
REQ-007 IDLE: IM_we=0, load_done=0, load_error=0, IM_Addr=0, byte counter=0.
- rx_done is ignored.
- load_flag=1 -> GETCNT.
REQ-008 rx_done SHALL be accepted only in GETCNT, GETINST and WRITE; it SHALL be ignored in IDLE, DONE and ERROR.
REQ-009 GETCNT: when the 4th byte is accepted, the assembled word A is latched as N, and:
- A=0 -> DONE;
- A>IM_MEM_SIZE -> ERROR;
- otherwise -> GETINST, with word index=0.
REQ-010 GETINST: when the 4th byte is accepted:
- IM_Data <= assembled word;
- IM_Addr <= word index;
- IM_we <= 1;
- next state WRITE.
REQ-011 WRITE lasts exactly one cycle with IM_we=1. On exit:
- IM_we <= 0 and the word index increments;
- if index+1 equals N -> DONE, else -> GETINST.
REQ-012 Latency: IM_we SHALL be high in the cycle immediately after the edge that samples the 4th rx_done of a word, for exactly one cycle. IM_Data and IM_Addr SHALL be stable for that whole cycle.
REQ-013 A byte arriving (rx_done=1) in WRITE SHALL be assembled normally and SHALL NOT be lost.
REQ-014 The word index and N comparison SHALL use IM_ADDR_LENGTH-bit unsigned arithmetic. N=IM_MEM_SIZE is legal; the last write then goes to address IM_MEM_SIZE-1.
REQ-015 DONE: load_done=1 for one cycle, then -> IDLE.
REQ-016 ERROR: load_error=1 for one cycle, no IM writes occur, then -> IDLE.
REQ-017 load_flag SHALL be ignored outside IDLE. IM_Data SHALL hold its last value until the next write.
REQ-018 Any undefined state SHALL return to IDLE on the next edge with all pulse outputs at 0.

Reset
REQ-019 While reset=0, the block SHALL immediately enter IDLE, independent of clk, with:
- IM_Addr=0, IM_Data=0, IM_we=0, load_done=0, load_error=0;
- byte counter=0, shift register=0, N=0, word index=0.
REQ-020 Reset asserted mid-load SHALL abort the load:
- no further IM_we pulses;
- no load_done;
- after release, the block waits in IDLE for a new load_flag.

Verification
REQ-021 Basic load: load_flag, then bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0 -> IM_we pulses at addr 0 with 0x12345678 and at addr 1 with 0x9ABCDEF0, then a single load_done pulse.
REQ-022 Zero count: count bytes 00 00 00 00 -> load_done pulses one cycle after DONE entry; no IM_we pulses.
REQ-023 Oversize count: count 0x00000401 with IM_MEM_SIZE=1024 -> one load_error pulse; no IM_we; subsequent bytes are ignored until the next load_flag.
REQ-024 Full depth: count 0x00000400 followed by 1024 words -> 1024 IM_we pulses; last at addr 0x3FF; then load_done.
REQ-025 Back-to-back bytes: the first byte of word 2 arrives in the WRITE cycle of word 1 -> word 2 is assembled correctly and written to addr 1.
REQ-026 Reset mid-load: assert reset=0 after 2 of 3 words -> all outputs go to 0 immediately; no load_done; a fresh load_flag with count 1 then writes to addr 0.
